// File: rtl/regs_pkg.sv
// Shared types and constants for the register-file writeback stage.
// Holds the load-queue entry type and the RISC-V load extraction helper.
package regs_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } lq_entry_t;

  // Select the addressed byte/half of an aligned word and extend it; unknown funct3 acts as LW.
  function automatic logic [XLEN-1:0] ld_extract(input logic [2:0]      f3,
                                                 input logic [1:0]      lo,
                                                 input logic [XLEN-1:0] word);
    logic [7:0]      b;
    logic [15:0]     h;
    logic [XLEN-1:0] res;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   res = {{(XLEN-8){b[7]}}, b};
      F3_LH:   res = {{(XLEN-16){h[15]}}, h};
      F3_LBU:  res = {{(XLEN-8){1'b0}}, b};
      F3_LHU:  res = {{(XLEN-16){1'b0}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/wb_load_fifo.sv
// Small synchronous FIFO buffering formatted load results for the writeback stage.
// Depth must be a power of two so the pointers wrap for free.
module wb_load_fifo
  import regs_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lq_entry_t                push_data,
  input  logic                     pop,
  output lq_entry_t                head,
  output logic [$clog2(Depth):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  lq_entry_t             mem_q [Depth];
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: only entries counted by count_q are ever read.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/regs_writeback.sv
// Writeback stage: arbitrates ALU and load results onto the register-file write port.
// Define REGS_WB_BYPASS_EN to forward the registered write to rs1_data/rs2_data.
module regs_writeback
  import regs_pkg::*;
#(
  parameter int unsigned LQ_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [4:0]        ld_rd,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_addr_lo,
  input  logic [XLEN-1:0]   ld_word,
  output logic [XLEN-1:0]   data_D,
  output logic [4:0]        addr_D,
  output logic              Wen,
  input  logic [4:0]        addr_A,
  input  logic [4:0]        addr_B,
  input  logic [XLEN-1:0]   data_A,
  input  logic [XLEN-1:0]   data_B,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data
);

  lq_entry_t                  ld_entry, lq_head;
  logic [$clog2(LQ_DEPTH):0]  lq_count;
  logic                       lq_full, lq_empty;
  logic                       lq_push, lq_pop;
  logic                       ld_acc;

  logic                       wr_any;
  logic [REG_AW-1:0]          wr_rd;
  logic [XLEN-1:0]            wr_data;
  logic                       wen_d, wen_q;
  logic [REG_AW-1:0]          addr_q;
  logic [XLEN-1:0]            data_q;

  // Full is derived from the registered count, so a same-cycle pop never raises ld_ready.
  assign ld_ready      = !lq_full;
  assign ld_acc        = ld_valid && ld_ready;
  assign ld_entry.rd   = ld_rd;
  assign ld_entry.data = ld_extract(ld_funct3, ld_addr_lo, ld_word);

  wb_load_fifo #(
    .Depth (LQ_DEPTH)
  ) u_load_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (lq_push),
    .push_data (ld_entry),
    .pop       (lq_pop),
    .head      (lq_head),
    .count     (lq_count),
    .full      (lq_full),
    .empty     (lq_empty)
  );

  always_comb begin
    wr_any  = 1'b0;
    wr_rd   = '0;
    wr_data = '0;
    lq_push = 1'b0;
    lq_pop  = 1'b0;
    if (alu_valid) begin
      wr_any  = 1'b1;
      wr_rd   = alu_rd;
      wr_data = alu_data;
      lq_push = ld_acc;
    end else if (!lq_empty) begin
      wr_any  = 1'b1;
      wr_rd   = lq_head.rd;
      wr_data = lq_head.data;
      lq_pop  = 1'b1;
      lq_push = ld_acc;
    end else if (ld_acc) begin
      wr_any  = 1'b1;
      wr_rd   = ld_entry.rd;
      wr_data = ld_entry.data;
    end
    // x0 writes are consumed but never reach the register file.
    wen_d = wr_any && (wr_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      wen_q <= wen_d;
      if (wen_d) begin
        addr_q <= wr_rd;
        data_q <= wr_data;
      end
    end
  end

  assign Wen    = wen_q;
  assign addr_D = addr_q;
  assign data_D = data_q;

`ifdef REGS_WB_BYPASS_EN
  logic hit_a, hit_b;
  assign hit_a    = wen_q && (addr_q == addr_A) && (addr_q != '0);
  assign hit_b    = wen_q && (addr_q == addr_B) && (addr_q != '0);
  assign rs1_data = hit_a ? data_q : data_A;
  assign rs2_data = hit_b ? data_q : data_B;
`else
  assign rs1_data = data_A;
  assign rs2_data = data_B;
`endif

  logic unused_count;
  assign unused_count = ^lq_count;

endmodule

// File: tb/tb_regs_writeback.sv
// Directed self-checking bench for regs_writeback with hand-computed expectations.
module tb_regs_writeback;
  import regs_pkg::*;

  logic              clk = 1'b0;
  logic              rst;
  logic              alu_valid;
  logic [4:0]        alu_rd;
  logic [XLEN-1:0]   alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [4:0]        ld_rd;
  logic [2:0]        ld_funct3;
  logic [1:0]        ld_addr_lo;
  logic [XLEN-1:0]   ld_word;
  logic [XLEN-1:0]   data_D;
  logic [4:0]        addr_D;
  logic              Wen;
  logic [4:0]        addr_A, addr_B;
  logic [XLEN-1:0]   data_A, data_B;
  logic [XLEN-1:0]   rs1_data, rs2_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regs_writeback #(
    .LQ_DEPTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_funct3  (ld_funct3),
    .ld_addr_lo (ld_addr_lo),
    .ld_word    (ld_word),
    .data_D     (data_D),
    .addr_D     (addr_D),
    .Wen        (Wen),
    .addr_A     (addr_A),
    .addr_B     (addr_B),
    .data_A     (data_A),
    .data_B     (data_B),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_wr(input string tag, input logic wen, input logic [4:0] rd,
                          input logic [31:0] data);
    check({tag, ".Wen"}, 32'(Wen), 32'(wen));
    if (wen) begin
      check({tag, ".addr"}, 32'(addr_D), 32'(rd));
      check({tag, ".data"}, data_D, data);
    end
  endtask

  task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    alu_valid = v;
    alu_rd    = rd;
    alu_data  = d;
  endtask

  task automatic ld(input logic v, input logic [4:0] rd, input logic [2:0] f3,
                    input logic [1:0] lo, input logic [31:0] w);
    ld_valid   = v;
    ld_rd      = rd;
    ld_funct3  = f3;
    ld_addr_lo = lo;
    ld_word    = w;
  endtask

  logic [31:0] exp_rs1;

  initial begin
    rst = 1'b1;
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, 3'b010, 2'd0, 32'h0);
    addr_A = 5'd0; addr_B = 5'd0; data_A = 32'h0; data_B = 32'h0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst.Wen", 32'(Wen), 32'd0);
    check("rst.addr", 32'(addr_D), 32'd0);
    check("rst.data", data_D, 32'h0);
    check("rst.ready", 32'(ld_ready), 32'd1);

    // ALU single-cycle latency
    alu(1'b1, 5'd5, 32'h1234);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    check_wr("alu", 1'b1, 5'd5, 32'h1234);

    // Direct load writes with extraction
    ld(1'b1, 5'd7, F3_LB, 2'd3, 32'h80FF_0000);
    tick();
    check_wr("lb", 1'b1, 5'd7, 32'hFFFF_FF80);
    ld(1'b1, 5'd7, F3_LBU, 2'd3, 32'h80FF_0000);
    tick();
    check_wr("lbu", 1'b1, 5'd7, 32'h0000_0080);
    ld(1'b1, 5'd8, F3_LHU, 2'd2, 32'h80FF_0000);
    tick();
    check_wr("lhu", 1'b1, 5'd8, 32'h0000_80FF);
    ld(1'b1, 5'd8, F3_LH, 2'd2, 32'h80FF_0000);
    tick();
    check_wr("lh_hi", 1'b1, 5'd8, 32'hFFFF_80FF);
    ld(1'b1, 5'd9, F3_LH, 2'd0, 32'h1234_8001);
    tick();
    check_wr("lh_lo", 1'b1, 5'd9, 32'hFFFF_8001);
    ld(1'b1, 5'd9, F3_LB, 2'd1, 32'h1234_7F01);
    tick();
    check_wr("lb_pos", 1'b1, 5'd9, 32'h0000_007F);
    ld(1'b1, 5'd10, 3'b111, 2'd1, 32'hDEAD_BEEF);
    tick();
    check_wr("lw_dflt", 1'b1, 5'd10, 32'hDEAD_BEEF);
    ld(1'b0, 5'd0, F3_LW, 2'd0, 32'h0);
    tick();
    check("idle.Wen", 32'(Wen), 32'd0);

    // ALU occupies the port for 4 cycles while 3 loads are offered
    alu(1'b1, 5'd1, 32'h101);
    ld(1'b1, 5'd10, F3_LW, 2'd0, 32'hA);
    check("q0.ready", 32'(ld_ready), 32'd1);
    tick();
    check_wr("q0", 1'b1, 5'd1, 32'h101);
    alu(1'b1, 5'd2, 32'h102);
    ld(1'b1, 5'd11, F3_LW, 2'd0, 32'hB);
    check("q1.ready", 32'(ld_ready), 32'd1);
    tick();
    check_wr("q1", 1'b1, 5'd2, 32'h102);
    alu(1'b1, 5'd3, 32'h103);
    ld(1'b1, 5'd12, F3_LW, 2'd0, 32'hC);
    check("q2.ready", 32'(ld_ready), 32'd0);
    tick();
    check_wr("q2", 1'b1, 5'd3, 32'h103);
    alu(1'b1, 5'd4, 32'h104);
    check("q3.ready", 32'(ld_ready), 32'd0);
    tick();
    check_wr("q3", 1'b1, 5'd4, 32'h104);
    alu(1'b0, 5'd0, 32'h0);
    check("q4.ready", 32'(ld_ready), 32'd0);
    tick();
    check_wr("q4", 1'b1, 5'd10, 32'hA);
    check("q5.ready", 32'(ld_ready), 32'd1);
    tick();
    ld(1'b0, 5'd0, F3_LW, 2'd0, 32'h0);
    check_wr("q5", 1'b1, 5'd11, 32'hB);
    tick();
    check_wr("q6", 1'b1, 5'd12, 32'hC);
    tick();
    check("q7.Wen", 32'(Wen), 32'd0);

    // x0 destinations are dropped
    alu(1'b1, 5'd0, 32'h55);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    check("alu_x0.Wen", 32'(Wen), 32'd0);
    ld(1'b1, 5'd0, F3_LW, 2'd0, 32'h66);
    tick();
    ld(1'b0, 5'd0, F3_LW, 2'd0, 32'h0);
    check("ld_x0.Wen", 32'(Wen), 32'd0);
    check("ld_x0.ready", 32'(ld_ready), 32'd1);
    tick();
    check("ld_x0.after", 32'(Wen), 32'd0);

    // Reset flushes queued loads
    alu(1'b1, 5'd3, 32'h33);
    ld(1'b1, 5'd13, F3_LW, 2'd0, 32'hD);
    tick();
    alu(1'b1, 5'd4, 32'h44);
    ld(1'b1, 5'd14, F3_LW, 2'd0, 32'hE);
    tick();
    check("flush.full", 32'(ld_ready), 32'd0);
    alu(1'b0, 5'd0, 32'h0);
    ld(1'b0, 5'd0, F3_LW, 2'd0, 32'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("flush.Wen", 32'(Wen), 32'd0);
    check("flush.ready", 32'(ld_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("flush.noWr", 32'(Wen), 32'd0);
    end

    // Bypass
    alu(1'b1, 5'd9, 32'hAA);
    tick();
    alu(1'b0, 5'd0, 32'h0);
    addr_A = 5'd9; data_A = 32'h11;
    addr_B = 5'd3; data_B = 32'h22;
    #1;
`ifdef REGS_WB_BYPASS_EN
    exp_rs1 = 32'hAA;
`else
    exp_rs1 = 32'h11;
`endif
    check("byp.rs1", rs1_data, exp_rs1);
    check("byp.rs2", rs2_data, 32'h22);
    addr_B = 5'd9; data_B = 32'h77;
    #1;
`ifdef REGS_WB_BYPASS_EN
    check("byp.rs2hit", rs2_data, 32'hAA);
`else
    check("byp.rs2hit", rs2_data, 32'h77);
`endif
    tick();
    check("byp.idle", rs1_data, 32'h11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
